// File: rtl/minmax_scan_ctrl_pkg.sv
// Shared definitions for the min/max frame scanner.
//   - state_e   : sequencer state encoding (IDLE..DONE)
//   - cmp_res_t : result bundle of the shared magnitude comparator
//   - DEF_WIDTH / DEF_LEN_W : default sample and length field widths
package minmax_scan_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_ACCEPT  = 3'd2,
    ST_CMP_MAX = 3'd3,
    ST_CMP_MIN = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef struct packed {
    logic less;
    logic equal;
    logic greater;
  } cmp_res_t;

endpackage

// File: rtl/minmax_scan_ctrl_mag_compare.sv
// Combinational unsigned magnitude comparator.
// Ports:
//   a, b    : WIDTH-bit unsigned operands
//   less    : a <  b
//   equal   : a == b
//   greater : a >  b
module mag_compare
  import minmax_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  always_comb begin
    less    = (a <  b);
    equal   = (a == b);
    greater = (a >  b);
  end

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Frame min/max scanner. Accepts len_i unsigned samples over a valid/ready
// stream and reports the maximum, minimum and the index of the first
// occurrence of each, using a single comparator shared between the max and
// min update steps.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_i, len_i          : start a frame of len_i samples (IDLE only)
//   in_valid_i, in_data_i   : sample stream input
//   in_ready_o              : sample accepted this cycle when valid
//   busy_o                  : sequencer not idle
//   done_o                  : one-cycle pulse, results final
//   empty_o                 : last frame had zero length, results invalid
//   max_o, min_o            : extreme values of last frame
//   max_idx_o, min_idx_o    : 0-based index of first occurrence
module minmax_scan_ctrl
  import minmax_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o,
  output logic [LEN_W-1:0] max_idx_o,
  output logic [LEN_W-1:0] min_idx_o
);

  state_e           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic [LEN_W-1:0] max_idx_q;
  logic [LEN_W-1:0] min_idx_q;
  logic             empty_q;

  logic [WIDTH-1:0] cmp_b;
  cmp_res_t         cmp;
  logic             upd_max;
  logic             upd_min;

  // The single comparator always sees the held sample on its A side; only the
  // B side is switched, selecting the running min during CMP_MIN and the
  // running max otherwise.
  always_comb begin
    cmp_b = max_q;
    if (state == ST_CMP_MIN) begin
      cmp_b = min_q;
    end
  end

  mag_compare #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a       (hold_q),
    .b       (cmp_b),
    .less    (cmp.less),
    .equal   (cmp.equal),
    .greater (cmp.greater)
  );

  // Ties never move a result, so the first occurrence keeps its index.
  always_comb begin
    upd_max = cmp.greater & ~cmp.equal;
    upd_min = cmp.less    & ~cmp.equal;
    cnt_inc = cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              // Zero-length frame: report immediately, results flagged invalid.
              empty_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              len_q   <= len_i;
              cnt_q   <= '0;
              empty_q <= 1'b0;
              state   <= ST_FIRST;
            end
          end
        end
        ST_FIRST: begin
          if (in_valid_i) begin
            // First sample seeds both extremes without a compare.
            max_q     <= in_data_i;
            min_q     <= in_data_i;
            max_idx_q <= '0;
            min_idx_q <= '0;
            cnt_q     <= LEN_W'(1);
            state     <= (len_q == LEN_W'(1)) ? ST_DONE : ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (in_valid_i) begin
            hold_q <= in_data_i;
            state  <= ST_CMP_MAX;
          end
        end
        ST_CMP_MAX: begin
          if (upd_max) begin
            max_q     <= hold_q;
            max_idx_q <= cnt_q;
          end
          state <= ST_CMP_MIN;
        end
        ST_CMP_MIN: begin
          if (upd_min) begin
            min_q     <= hold_q;
            min_idx_q <= cnt_q;
          end
          cnt_q <= cnt_inc;
          state <= (cnt_inc == len_q) ? ST_DONE : ST_ACCEPT;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    in_ready_o = (state == ST_FIRST) || (state == ST_ACCEPT);
    busy_o     = (state != ST_IDLE);
    done_o     = (state == ST_DONE);
    empty_o    = empty_q;
    max_o      = max_q;
    min_o      = min_q;
    max_idx_o  = max_idx_q;
    min_idx_o  = min_idx_q;
  end

endmodule
